cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Sits directly downstream of the execute stage. Each cycle it consumes the per-FU result slots (done, rob_tag, value, indices 1..NUM_FU) and grants exactly one FU the common data bus.
- Returns a one-hot ack to the execute stage so the granted FU can release its held result.
- Broadcasts the granted result on a registered CDB to the RS, ROB and map table.
- Arbitration is round-robin across FUs 1..NUM_FU, so no FU starves. Index 0 is a reserved null slot and is never granted.

Parameters:
- NUM_FU, 6, highest FU index; slots 1..NUM_FU are arbitrated, slot 0 is ignored.
- XLEN, 32, result value width.
- ROB_TAG_W, 5, ROB tag width.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- fu_done  input  NUM_FU+1  per-FU result-valid flag, held by the FU until acked.
- fu_rob_tag  input  (NUM_FU+1)*ROB_TAG_W  per-FU ROB tag; slot i occupies bits [i*ROB_TAG_W +: ROB_TAG_W].
- fu_value  input  (NUM_FU+1)*XLEN  per-FU result value, packed the same way.
- squash  input  1  branch mispredict flush from ROB retire.
- ack  output  NUM_FU+1  combinational one-hot grant back to the execute stage; ack[0] is always 0.
- cdb_valid  output  1  registered broadcast valid.
- cdb_rob_tag  output  ROB_TAG_W  registered broadcast ROB tag.
- cdb_value  output  XLEN  registered broadcast value.
- cdb_fu_idx  output  $clog2(NUM_FU+1)  registered index of the broadcasting FU, for debug and perf.

Behaviour:
- State:
  - last_grant pointer, range 1..NUM_FU.
  - CDB output register: cdb_valid, cdb_rob_tag, cdb_value, cdb_fu_idx.
- Reset, sampled on clock edge:
  - last_grant = NUM_FU, so the first search starts at FU 1.
  - cdb_valid = 0, cdb_rob_tag = 0, cdb_value = 0, cdb_fu_idx = 0.
  - During reset, ack is forced to all-zero.
- Grant, combinational:
  - Search order is last_grant+1, last_grant+2, ... wrapping NUM_FU -> 1, for NUM_FU candidates.
  - The first i with fu_done[i] = 1 gets ack[i] = 1.
  - fu_done[0] is ignored.
  - At most one ack bit is high in any cycle.
- Latency:
  - A result granted in cycle N appears on the CDB in cycle N+1.
  - Throughput is one broadcast per cycle.
  - The FU must drop done (or present its next result) in cycle N+1.
- Register update on each edge, no reset, no squash:
  - If a grant occurs: cdb_valid <= 1, tag/value/idx <= granted slot, last_grant <= granted index.
  - If no grant: cdb_valid <= 0; tag, value, idx and last_grant keep their values.
- Squash:
  - In a squash cycle, ack = 0.
  - Next edge: cdb_valid <= 0; last_grant is unchanged.
  - A squash does not clear a broadcast already on the CDB in the squash cycle; that broadcast completes.
  - FUs are flushed externally; the arbiter holds no pending queue.
- Idle: if all fu_done = 0, then ack = 0 and cdb_valid drops the next cycle.
- Single requester: a lone requester is granted every cycle it is done. Back-to-back grants to the same FU are legal.
- Wrap: with last_grant = NUM_FU, the search starts at 1.
- Reset mid-operation: a pending done is not acked; after reset deasserts, arbitration restarts with FU 1 at highest priority.
- No combinational path exists from any input to cdb_* outputs.
- ack depends only on fu_done, squash, reset and last_grant.

Test Plan:
1. Reset then idle: hold reset 2 cycles, all fu_done = 0 -> ack = 0, cdb_valid = 0 every cycle, all cdb_* outputs = 0.
2. Single request: fu_done[3] = 1, tag = 7, value = 0xDEADBEEF for one cycle -> ack = 0b0001000 that cycle; next cycle cdb_valid = 1, cdb_rob_tag = 7, cdb_value = 0xDEADBEEF, cdb_fu_idx = 3; the cycle after, cdb_valid = 0.
3. Round-robin fairness: fu_done[1], [2] and [5] held high, each dropping only after its ack -> grant order 1, 2, 5. Then with all six held continuously -> grant order 1, 2, 3, 4, 5, 6, 1 (wrap).
4. Slot 0 ignore: fu_done = 0b0000001 only -> ack = 0, cdb_valid stays 0.
5. Squash: fu_done[2] = 1 and squash = 1 in the same cycle -> ack = 0; next cycle cdb_valid = 0; last_grant unchanged, so a later grant follows the pre-squash order.
6. Reset mid-stream: all FUs done, last_grant = 4, assert reset one cycle -> ack = 0 during reset; the first grant after reset goes to FU 1.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Execute-stage result slots, squash and ack toward the arbiter, plus the
// registered common data bus it broadcasts to the RS, ROB and map table.
interface cdb_arbiter_if #(
  parameter int NUM_FU    = 6,
  parameter int XLEN      = 32,
  parameter int ROB_TAG_W = 5
);
  localparam int IDX_W = $clog2(NUM_FU + 1);

  logic [NUM_FU:0]                 fu_done;
  logic [(NUM_FU+1)*ROB_TAG_W-1:0] fu_rob_tag;
  logic [(NUM_FU+1)*XLEN-1:0]      fu_value;
  logic                            squash;
  logic [NUM_FU:0]                 ack;
  logic                            cdb_valid;
  logic [ROB_TAG_W-1:0]            cdb_rob_tag;
  logic [XLEN-1:0]                 cdb_value;
  logic [IDX_W-1:0]                cdb_fu_idx;

  modport master (
    output fu_done, fu_rob_tag, fu_value, squash,
    input  ack, cdb_valid, cdb_rob_tag, cdb_value, cdb_fu_idx
  );

  modport slave (
    input  fu_done, fu_rob_tag, fu_value, squash,
    output ack, cdb_valid, cdb_rob_tag, cdb_value, cdb_fu_idx
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: grants one of FUs 1..NUM_FU per cycle
// with a combinational one-hot ack and a registered CDB broadcast.
module cdb_arbiter #(
  parameter int NUM_FU    = 6,
  parameter int XLEN      = 32,
  parameter int ROB_TAG_W = 5
) (
  input  logic          clock,
  input  logic          reset,
  cdb_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_FU + 1);

  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [ROB_TAG_W-1:0] cdb_rob_tag_q, cdb_rob_tag_d;
  logic [XLEN-1:0]      cdb_value_q, cdb_value_d;
  logic [IDX_W-1:0]     cdb_fu_idx_q, cdb_fu_idx_d;

  logic                 grant_vld;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     cand;
  logic [NUM_FU:0]      ack_vec;
  int                   slot;

  // Search starts just past the last winner and wraps NUM_FU -> 1, never 0.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    slot      = 0;
    if (!reset && !bus.squash) begin
      for (int k = 1; k <= NUM_FU; k++) begin
        slot = int'(last_grant_q) + k;
        if (slot > NUM_FU) begin
          slot = slot - NUM_FU;
        end
        cand = IDX_W'(slot);
        if (!grant_vld && bus.fu_done[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi <= NUM_FU; gi++) begin : g_ack
      if (gi == 0) begin : g_null
        assign ack_vec[gi] = 1'b0;
      end else begin : g_fu
        assign ack_vec[gi] = grant_vld && (grant_idx == IDX_W'(gi));
      end
    end
  endgenerate

  assign bus.ack = ack_vec;

  // Tag, value, index and pointer only move on a grant.
  always_comb begin
    cdb_valid_d   = grant_vld;
    cdb_rob_tag_d = cdb_rob_tag_q;
    cdb_value_d   = cdb_value_q;
    cdb_fu_idx_d  = cdb_fu_idx_q;
    last_grant_d  = last_grant_q;
    if (grant_vld) begin
      cdb_rob_tag_d = bus.fu_rob_tag[grant_idx*ROB_TAG_W +: ROB_TAG_W];
      cdb_value_d   = bus.fu_value[grant_idx*XLEN +: XLEN];
      cdb_fu_idx_d  = grant_idx;
      last_grant_d  = grant_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q  <= IDX_W'(NUM_FU);
      cdb_valid_q   <= 1'b0;
      cdb_rob_tag_q <= '0;
      cdb_value_q   <= '0;
      cdb_fu_idx_q  <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_rob_tag_q <= cdb_rob_tag_d;
      cdb_value_q   <= cdb_value_d;
      cdb_fu_idx_q  <= cdb_fu_idx_d;
    end
  end

  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_rob_tag = cdb_rob_tag_q;
  assign bus.cdb_value   = cdb_value_q;
  assign bus.cdb_fu_idx  = cdb_fu_idx_q;

  // Slot 0 is a null slot; its fields are deliberately left unconsumed.
  logic unused_slot0;
  assign unused_slot0 = ^{bus.fu_done[0], bus.fu_rob_tag[ROB_TAG_W-1:0], bus.fu_value[XLEN-1:0]};

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus a randomized run, all checked
// against a queue-based round-robin reference model.
module tb_cdb_arbiter;
  localparam int NUM_FU = 6;
  localparam int XLEN   = 32;
  localparam int TW     = 5;
  localparam int IW     = $clog2(NUM_FU + 1);

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cdb_arbiter_if #(.NUM_FU(NUM_FU), .XLEN(XLEN), .ROB_TAG_W(TW)) bus ();

  cdb_arbiter #(.NUM_FU(NUM_FU), .XLEN(XLEN), .ROB_TAG_W(TW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int              m_last;
  logic            m_valid;
  logic [TW-1:0]   m_tag;
  logic [XLEN-1:0] m_value;
  logic [IW-1:0]   m_idx;

  logic [NUM_FU:0] got, exp;

  // Candidates in priority order: last+1, last+2, ... wrapped into 1..NUM_FU.
  function automatic logic [NUM_FU:0] model_ack();
    logic [NUM_FU:0] r = '0;
    int order[$];
    if (reset || bus.squash) return r;
    for (int i = m_last + 1; i <= m_last + NUM_FU; i++)
      order.push_back(i > NUM_FU ? i - NUM_FU : i);
    foreach (order[j]) begin
      if (bus.fu_done[order[j]]) begin
        r[order[j]] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // Advance one cycle: sample ack at negedge, update the model at posedge.
  task automatic clk_step(output logic [NUM_FU:0] ack_seen);
    logic [NUM_FU:0] e;
    @(negedge clock);
    ack_seen = bus.ack;
    e = model_ack();
    @(posedge clock);
    if (reset) begin
      m_last = NUM_FU; m_valid = 1'b0; m_tag = '0; m_value = '0; m_idx = '0;
    end else if (e != '0) begin
      for (int i = 1; i <= NUM_FU; i++) begin
        if (e[i]) begin
          m_last  = i;
          m_idx   = IW'(i);
          m_tag   = bus.fu_rob_tag[i*TW +: TW];
          m_value = bus.fu_value[i*XLEN +: XLEN];
        end
      end
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic randomize_payload();
    bus.fu_rob_tag = (NUM_FU+1)*TW'({$urandom(), $urandom()});
    for (int i = 0; i <= NUM_FU; i++) bus.fu_value[i*XLEN +: XLEN] = $urandom();
  endtask

  task automatic reset_pulse();
    logic [NUM_FU:0] dummy;
    reset = 1'b1;
    clk_step(dummy);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.fu_done = '0;
    bus.squash = 1'b0;
    randomize_payload();
    repeat (2) begin
      clk_step(got);
      checks++;
      if (got !== '0) begin
        errors++; $display("FAIL reset_ack got %b want %b", got, 7'b0);
      end
      checks++;
      if ({bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_value, bus.cdb_fu_idx} !== '0) begin
        errors++;
        $display("FAIL reset_cdb got v=%b tag=%h val=%h idx=%0d want all zero",
                 bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_value, bus.cdb_fu_idx);
      end
    end
    reset = 1'b0;
    clk_step(got);
    checks++;
    if (got !== '0 || bus.cdb_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got ack=%b v=%b want ack=0 v=0", got, bus.cdb_valid);
    end
  endtask

  task automatic test_single();
    bus.fu_rob_tag[3*TW +: TW]   = 5'd7;
    bus.fu_value[3*XLEN +: XLEN] = 32'hDEADBEEF;
    bus.fu_done = 7'b0001000;
    clk_step(got);
    checks++;
    if (got !== 7'b0001000) begin
      errors++; $display("FAIL single_ack got %b want %b", got, 7'b0001000);
    end
    checks++;
    if ({bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_value, bus.cdb_fu_idx} !== {1'b1, 5'd7, 32'hDEADBEEF, 3'd3}) begin
      errors++;
      $display("FAIL single_cdb got v=%b tag=%0d val=%h idx=%0d want v=1 tag=7 val=deadbeef idx=3",
               bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_value, bus.cdb_fu_idx);
    end
    bus.fu_done = '0;
    clk_step(got);
    checks++;
    if (got !== '0 || bus.cdb_valid !== 1'b0) begin
      errors++; $display("FAIL single_drop got ack=%b v=%b want ack=0 v=0", got, bus.cdb_valid);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int want_a[3] = '{1, 2, 5};
    int want_b[7] = '{1, 2, 3, 4, 5, 6, 1};
    reset_pulse();
    randomize_payload();
    bus.fu_done = 7'b0100110;
    for (int c = 0; c < 10 && bus.fu_done != '0; c++) begin
      exp = model_ack();
      clk_step(got);
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rr_hold_ack got %b want %b", got, exp);
      end
      for (int i = 1; i <= NUM_FU; i++) begin
        if (got[i]) begin
          order.push_back(i);
          bus.fu_done[i] = 1'b0;
        end
      end
    end
    checks++;
    if (order.size() != 3 || order[0] != want_a[0] || order[1] != want_a[1] || order[2] != want_a[2]) begin
      errors++; $display("FAIL rr_order got %p want %p", order, want_a);
    end
    reset_pulse();
    bus.fu_done = 7'b1111110;
    for (int c = 0; c < 7; c++) begin
      clk_step(got);
      checks++;
      if (got !== (7'b1 << want_b[c])) begin
        errors++; $display("FAIL rr_all_ack step %0d got %b want FU %0d", c, got, want_b[c]);
      end
      checks++;
      if (bus.cdb_fu_idx !== m_idx || bus.cdb_valid !== 1'b1) begin
        errors++; $display("FAIL rr_all_cdb got idx=%0d v=%b want idx=%0d v=1", bus.cdb_fu_idx, bus.cdb_valid, m_idx);
      end
    end
  endtask

  task automatic test_slot0();
    bus.fu_done = 7'b0000001;
    repeat (3) begin
      clk_step(got);
      checks++;
      if (got !== '0 || bus.cdb_valid !== 1'b0) begin
        errors++; $display("FAIL slot0 got ack=%b v=%b want ack=0 v=0", got, bus.cdb_valid);
      end
    end
  endtask

  task automatic test_squash();
    reset_pulse();
    bus.fu_done = 7'b0000010;
    clk_step(got);
    checks++;
    if (got !== 7'b0000010) begin
      errors++; $display("FAIL squash_pre_ack got %b want %b", got, 7'b0000010);
    end
    bus.fu_done = 7'b0000100;
    bus.squash  = 1'b1;
    checks++;
    if (bus.cdb_valid !== 1'b1) begin
      errors++; $display("FAIL squash_inflight got v=%b want 1", bus.cdb_valid);
    end
    clk_step(got);
    checks++;
    if (got !== '0 || bus.cdb_valid !== 1'b0) begin
      errors++; $display("FAIL squash_cycle got ack=%b v=%b want ack=0 v=0", got, bus.cdb_valid);
    end
    bus.squash  = 1'b0;
    bus.fu_done = 7'b1000010;
    clk_step(got);
    checks++;
    if (got !== 7'b1000000) begin
      errors++; $display("FAIL squash_ptr_kept got %b want %b", got, 7'b1000000);
    end
    bus.fu_done = '0;
  endtask

  task automatic test_reset_mid();
    reset_pulse();
    bus.fu_done = 7'b1111110;
    for (int c = 1; c <= 4; c++) begin
      clk_step(got);
      checks++;
      if (got !== (7'b1 << c)) begin
        errors++; $display("FAIL mid_prefill got %b want FU %0d", got, c);
      end
    end
    reset = 1'b1;
    clk_step(got);
    checks++;
    if (got !== '0) begin
      errors++; $display("FAIL mid_reset_ack got %b want 0", got);
    end
    checks++;
    if ({bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_value, bus.cdb_fu_idx} !== '0) begin
      errors++; $display("FAIL mid_reset_cdb got v=%b idx=%0d want all zero", bus.cdb_valid, bus.cdb_fu_idx);
    end
    reset = 1'b0;
    clk_step(got);
    checks++;
    if (got !== 7'b0000010) begin
      errors++; $display("FAIL mid_restart got %b want %b", got, 7'b0000010);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset       = ($urandom_range(0, 39) == 0);
      bus.squash  = ($urandom_range(0, 7) == 0);
      bus.fu_done = (NUM_FU+1)'($urandom());
      randomize_payload();
      exp = model_ack();
      clk_step(got);
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rand_ack cycle %0d got %b want %b", c, got, exp);
      end
      checks++;
      if ({bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_value, bus.cdb_fu_idx} !== {m_valid, m_tag, m_value, m_idx}) begin
        errors++;
        $display("FAIL rand_cdb cycle %0d got v=%b tag=%h val=%h idx=%0d want v=%b tag=%h val=%h idx=%0d",
                 c, bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_value, bus.cdb_fu_idx,
                 m_valid, m_tag, m_value, m_idx);
      end
    end
    reset = 1'b0;
    bus.squash = 1'b0;
    bus.fu_done = '0;
  endtask

  initial begin
    m_last = NUM_FU; m_valid = 1'b0; m_tag = '0; m_value = '0; m_idx = '0;
    reset = 1'b1;
    bus.fu_done = '0;
    bus.squash = 1'b0;
    bus.fu_rob_tag = '0;
    bus.fu_value = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_slot0();
    test_squash();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
